// File: rtl/regfile_32x32.sv
// 32-entry register file: one write port, two combinational read ports with
// write-before-read bypass, optional hardwired-zero register 0, and a write acknowledge.
module regfile_32x32 #(
  parameter int WIDTH   = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [0:4]       waddr,
  input  logic [0:WIDTH-1] wdata,
  input  logic [0:4]       raddr_a,
  input  logic [0:4]       raddr_b,
  output logic [0:WIDTH-1] rdata_a,
  output logic [0:WIDTH-1] rdata_b,
  output logic             wr_ack
);

  // Interface contract: no handshake. A write with we=1 commits on the rising
  // clk edge, unless it targets a hardwired-zero r0. wr_ack is high for the one
  // cycle that follows each committed write.

  logic [0:WIDTH-1] mem_q [32];
  logic [0:WIDTH-1] mem_d [32];
  logic             wr_ack_q;
  logic             wr_ack_d;
  logic             wr_en;

  // A discarded r0 write never reaches storage, so mem_q[0] stays zero from reset.
  always_comb begin
    wr_en = we && !(R0_ZERO && (waddr == 5'd0));
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      mem_d[i] = (wr_en && (waddr == 5'(i))) ? wdata : mem_q[i];
    end
    wr_ack_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
      wr_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ack_q <= wr_ack_d;
    end
  end

  // Reads are forced to zero while reset is held, and bypass is suppressed as well.
  always_comb begin
    rdata_a = '0;
    if (rst_n) begin
      if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
      else                             rdata_a = mem_q[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (rst_n) begin
      if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
      else                             rdata_b = mem_q[raddr_b];
    end
  end

  assign wr_ack = wr_ack_q;

endmodule
